// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock: FSM encoding, digit limits and
// width helpers. Used by the digit-entry front end and the security block.
package lock_pkg;

   localparam int                  DIGIT_W   = 4;
   localparam logic [DIGIT_W-1:0]  DIGIT_MAX = 4'd9;

   localparam int         STATE_W    = 2;
   localparam logic [1:0] ST_EDIT    = 2'd0;
   localparam logic [1:0] ST_COMMIT  = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   // Width of a position index for n digits; never narrower than one bit.
   function automatic int pos_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Counter width able to hold values 0..n.
   function automatic int count_width(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

   // Mod-10 step: up alone increments, down alone decrements, both or
   // neither leave the digit unchanged.
   function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] d,
                                                     input logic up,
                                                     input logic down);
      logic [DIGIT_W-1:0] r;
      r = d;
      if (up && !down)
         r = (d == DIGIT_MAX) ? '0 : d + DIGIT_W'(1);
      else if (down && !up)
         r = (d == '0) ? DIGIT_MAX : d - DIGIT_W'(1);
      return r;
   endfunction

endpackage

// File: rtl/pass_digit_entry_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             level_q;

   // Bring the asynchronous button level into the clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Count consecutive disagreeing cycles; the DEB_CYCLES-th one flips the level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync2 == level) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
         cnt   <= '0;
         level <= sync2;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Remember the previous debounced level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_q <= 1'b0;
      else     level_q <= level;
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/pass_digit_entry.sv
// Digit-entry front end of the lock: conditions four buttons, edits a
// mod-10 digit at a mod-NUM_DIGITS position, and commits the code word.
// enter_1 is a one-cycle strobe with no back-pressure: code_out is valid in
// exactly the cycle enter_1 is high and the consumer must take it then.
module pass_digit_entry
   import lock_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int DEB_CYCLES = 16
) (
   input  logic                            clk,
   input  logic                            lock_rst,
   input  logic                            btn_up_raw,
   input  logic                            btn_down_raw,
   input  logic                            btn_next_raw,
   input  logic                            btn_enter_raw,
   input  logic                            lockout_in,
   output logic [DIGIT_W-1:0]              mod10_out,
   output logic [pos_width(NUM_DIGITS)-1:0] mod3_out,
   output logic [DIGIT_W*NUM_DIGITS-1:0]   code_out,
   output logic                            enter_1,
   output logic                            busy
);

   localparam int                POS_W    = pos_width(NUM_DIGITS);
   localparam logic [POS_W-1:0]  POS_LAST = POS_W'(NUM_DIGITS - 1);

   // Button index order: 0 up, 1 down, 2 next, 3 enter.
   logic [3:0] raw_btn;
   logic [3:0] lvl;
   logic [3:0] prs;

   logic [STATE_W-1:0]            state;
   logic [DIGIT_W-1:0]            digit;
   logic [POS_W-1:0]              pos;
   logic [POS_W-1:0]              npos;
   logic [DIGIT_W*NUM_DIGITS-1:0] slots;

   assign raw_btn = {btn_enter_raw, btn_next_raw, btn_down_raw, btn_up_raw};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk   (clk),
         .rst   (lock_rst),
         .raw   (raw_btn[g]),
         .level (lvl[g]),
         .press (prs[g])
      );
   end

   // Next position, wrapping at the last digit.
   always_comb begin
      npos = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
   end

   // Edit / commit / release sequencing with enter > next > up/down priority.
   always_ff @(posedge clk or posedge lock_rst) begin
      if (lock_rst) begin
         state    <= ST_EDIT;
         digit    <= '0;
         pos      <= '0;
         slots    <= '0;
         code_out <= '0;
         enter_1  <= 1'b0;
      end else begin
         enter_1 <= 1'b0;
         case (state)
            ST_EDIT: begin
               if (!lockout_in) begin
                  if (prs[3]) begin
                     slots[int'(pos)*DIGIT_W +: DIGIT_W] <= digit;
                     state <= ST_COMMIT;
                  end else if (prs[2]) begin
                     slots[int'(pos)*DIGIT_W +: DIGIT_W] <= digit;
                     pos   <= npos;
                     // With a single digit the reloaded slot is the one just written.
                     digit <= (npos == pos) ? digit : slots[int'(npos)*DIGIT_W +: DIGIT_W];
                  end else begin
                     digit <= digit_step(digit, prs[0], prs[1]);
                  end
               end
            end
            ST_COMMIT: begin
               code_out <= slots;
               enter_1  <= 1'b1;
               slots    <= '0;
               pos      <= '0;
               digit    <= '0;
               state    <= ST_RELEASE;
            end
            ST_RELEASE: begin
               if (lvl == 4'b0000) state <= ST_EDIT;
            end
            default: state <= ST_EDIT;
         endcase
      end
   end

   assign mod10_out = digit;
   assign mod3_out  = pos;
   assign busy      = (state == ST_COMMIT) || (state == ST_RELEASE);

endmodule
